// File: rtl/read_stage_pkg.sv
// Shared field widths and the request record carried through the VRF read-stage arbiters.
package read_stage_pkg;

    localparam int unsigned VS_W      = 5;
    localparam int unsigned GROUP_W   = 4;
    localparam int unsigned SRC_TAG_W = 4;
    localparam int unsigned INST_W    = 3;

    typedef struct packed {
        logic [VS_W-1:0]      vs;
        logic [GROUP_W-1:0]   group_index;
        logic [SRC_TAG_W-1:0] read_source;
        logic [INST_W-1:0]    instruction_index;
    } read_req_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first eligible index after ptr_i, wrapping modulo N.
module rr_pick #(
    parameter int unsigned N     = 4,
    parameter int unsigned SRC_W = 2
) (
    input  logic [N-1:0]     eligible_i,
    input  logic [SRC_W-1:0] ptr_i,
    output logic [SRC_W-1:0] winner_o,
    output logic             any_o
);

    logic [SRC_W-1:0] idx;
    logic             found;

    always_comb begin
        idx      = '0;
        found    = 1'b0;
        winner_o = '0;
        // Scan ptr+1 .. ptr+N so the last granted requester has lowest priority.
        for (int unsigned k = 1; k <= N; k++) begin
            idx = SRC_W'((32'(ptr_i) + k) % N);
            if (!found && eligible_i[idx]) begin
                winner_o = idx;
                found    = 1'b1;
            end
        end
    end

    assign any_o = found;

endmodule

// File: rtl/read_stage_rr_scheduler.sv
// Round-robin arbiter sharing one VRF read-stage slot; the winner is held in a one-entry
// output register with ready/valid handshake and instruction-kill support.
module read_stage_rr_scheduler
    import read_stage_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned SRC_W = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N-1:0]           io_in_valid,
    output logic [N-1:0]           io_in_ready,
    input  logic [VS_W*N-1:0]      io_in_bits_vs,
    input  logic [GROUP_W*N-1:0]   io_in_bits_groupIndex,
    input  logic [SRC_TAG_W*N-1:0] io_in_bits_readSource,
    input  logic [INST_W*N-1:0]    io_in_bits_instructionIndex,
    input  logic                   io_kill_valid,
    input  logic [INST_W-1:0]      io_kill_instructionIndex,
    input  logic                   io_out_ready,
    output logic                   io_out_valid,
    output logic [VS_W-1:0]        io_out_bits_vs,
    output logic [GROUP_W-1:0]     io_out_bits_groupIndex,
    output logic [SRC_TAG_W-1:0]   io_out_bits_readSource,
    output logic [INST_W-1:0]      io_out_bits_instructionIndex,
    output logic [SRC_W-1:0]       io_out_bits_source
);

    read_req_t        req [N];
    logic [N-1:0]     eligible;
    logic [SRC_W-1:0] winner;
    logic             any_eligible;
    logic             can_load;
    logic             load;
    logic             kill_held;

    logic             out_valid_q, out_valid_d;
    read_req_t        out_req_q, out_req_d;
    logic [SRC_W-1:0] out_src_q, out_src_d;
    logic [SRC_W-1:0] ptr_q, ptr_d;

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign req[i].vs                = io_in_bits_vs[i*VS_W +: VS_W];
        assign req[i].group_index       = io_in_bits_groupIndex[i*GROUP_W +: GROUP_W];
        assign req[i].read_source       = io_in_bits_readSource[i*SRC_TAG_W +: SRC_TAG_W];
        assign req[i].instruction_index = io_in_bits_instructionIndex[i*INST_W +: INST_W];
        // A killed instruction's request can never be loaded, even in the kill cycle.
        assign eligible[i] = io_in_valid[i] &&
            !(io_kill_valid && (req[i].instruction_index == io_kill_instructionIndex));
    end

    rr_pick #(
        .N     (N),
        .SRC_W (SRC_W)
    ) u_rr_pick (
        .eligible_i (eligible),
        .ptr_i      (ptr_q),
        .winner_o   (winner),
        .any_o      (any_eligible)
    );

    assign can_load  = !out_valid_q || io_out_ready;
    assign load      = can_load && any_eligible;
    // A kill never revokes a handshake completing in the same cycle.
    assign kill_held = io_kill_valid && out_valid_q && !io_out_ready &&
                       (out_req_q.instruction_index == io_kill_instructionIndex);

    always_comb begin
        io_in_ready = '0;
        if (load) begin
            io_in_ready[winner] = 1'b1;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_req_d   = out_req_q;
        out_src_d   = out_src_q;
        ptr_d       = ptr_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_req_d   = req[winner];
            out_src_d   = winner;
            ptr_d       = winner;
        end else if (out_valid_q && io_out_ready) begin
            out_valid_d = 1'b0;
        end else if (kill_held) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_req_q   <= '0;
            out_src_q   <= '0;
            ptr_q       <= SRC_W'(N - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_req_q   <= out_req_d;
            out_src_q   <= out_src_d;
            ptr_q       <= ptr_d;
        end
    end

    assign io_out_valid                 = out_valid_q;
    assign io_out_bits_vs               = out_req_q.vs;
    assign io_out_bits_groupIndex       = out_req_q.group_index;
    assign io_out_bits_readSource       = out_req_q.read_source;
    assign io_out_bits_instructionIndex = out_req_q.instruction_index;
    assign io_out_bits_source           = out_src_q;

endmodule

// File: doc/read_stage_rr_scheduler.md
Name: read_stage_rr_scheduler

Overview:
- N-way round-robin scheduler that shares one VRF read-stage request slot among several read requesters (lanes' operand/LSU/mask readers).
- Selects one valid request per cycle and captures it in a single-entry output pipeline register.
- Presents the captured request to the read stage with a ready/valid handshake.
- Supports an instruction kill that drops pending work belonging to a retired or aborted instruction.

Parameters:
- N, 4, number of requesters; at least 2.
- SRC_W, 2, width of io_out_bits_source; equals ceil(log2(N)).

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high reset
- io_in_valid  in  N  bit i is the request valid of requester i
- io_in_ready  out  N  bit i is the request accepted from requester i
- io_in_bits_vs  in  5*N  slice i is the vector register index
- io_in_bits_groupIndex  in  4*N  slice i is the group index
- io_in_bits_readSource  in  4*N  slice i is the read source tag
- io_in_bits_instructionIndex  in  3*N  slice i is the owning instruction
- io_kill_valid  in  1  kill strobe
- io_kill_instructionIndex  in  3  instruction to kill
- io_out_ready  in  1  read stage can accept
- io_out_valid  out  1  held request valid
- io_out_bits_vs  out  5  held vs
- io_out_bits_groupIndex  out  4  held groupIndex
- io_out_bits_readSource  out  4  held readSource
- io_out_bits_instructionIndex  out  3  held instructionIndex
- io_out_bits_source  out  SRC_W  requester index that won

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- State:
  - out_valid, 1 bit
  - out_bits: vs, groupIndex, readSource, instructionIndex, source
  - ptr, SRC_W bits: last granted requester
- Reset values:
  - out_valid = 0; out_bits = 0, so all io_out_bits_* read 0.
  - ptr = N-1, so requester 0 has first priority.
  - io_in_ready = 0 while out_valid = 0 and no request is valid.
- Eligibility: eligible[i] = io_in_valid[i] && !(io_kill_valid && io_in_bits_instructionIndex[i] == io_kill_instructionIndex).
- Priority order: (ptr+1) mod N, (ptr+2) mod N, ..., ptr. The winner is the first eligible requester in that order. Index arithmetic wraps modulo N; N need not be a power of 2.
- can_load = !out_valid || io_out_ready.
- io_in_ready[i] = can_load && winner == i. This path is combinational from io_out_ready; at most one bit is set. A request is transferred when io_in_valid[i] && io_in_ready[i].
- Transfer out = out_valid && io_out_ready.
- Load (can_load && any eligible), on the next edge:
  - out_bits <= winner's fields, source <= winner
  - out_valid <= 1
  - ptr <= winner
- No load:
  - ptr holds.
  - If transfer out occurred, out_valid <= 0.
- Kill of the held entry: io_kill_valid && out_valid && out_bits.instructionIndex matches && !io_out_ready, then out_valid <= 0 next cycle. If io_out_ready = 1 in the same cycle, the transfer completes; kill does not revoke a completed handshake.
- Kill with load in the same cycle: matching requests are ineligible, so a new load never carries the killed index.
- Latency: one cycle from input acceptance to io_out_valid. Full throughput of 1 request per cycle when io_out_ready stays high.
- Backpressure:
  - While out_valid && !io_out_ready, all io_in_ready = 0.
  - out_bits are stable, and ptr does not move.
- Fairness: a continuously valid requester is granted within N loads.
- Reset asserted mid-operation drops the held entry without a handshake; requesters must re-present.
- No X propagation: out_bits hold their value when not loading.

Decomposition:
- Shared package (read_stage_pkg):
  - field width constants VS_W=5, GROUP_W=4, SRC_TAG_W=4, INST_W=3
  - packed struct read_req_t {vs, groupIndex, readSource, instructionIndex}
- Sub-module rr_pick: combinational, inputs eligible[N] and ptr, outputs winner index and any. It is reused by other lane arbiters.

Test Plan (N=4):
1. Reset, then all io_in_valid=1 and io_out_ready=1 for 8 cycles. Requires winners 0,1,2,3,0,1,2,3, io_out_bits_source following one cycle later, and exactly one io_in_ready bit per cycle.
2. Only requester 2 valid with vs=5'd17, groupIndex=4'd9, readSource=4'd3, instructionIndex=3'd6. Requires io_in_ready=4'b0100 and, next cycle, io_out_valid=1 with vs=17, groupIndex=9, readSource=3, inst=6, source=2.
3. Hold io_out_ready=0 for 5 cycles with all requesters valid. Requires io_in_ready=0, out_bits stable and ptr unchanged. On release, the next grant is (held source+1) mod 4.
4. Held entry inst=3 with io_out_ready=0, then pulse io_kill_valid with inst=3. Requires io_out_valid=0 next cycle. Repeating with io_out_ready=1 in the same cycle requires the transfer to count and no loss.
5. Requesters 0 (inst=1) and 1 (inst=2) valid, kill inst=1, ptr=3. Requires requester 1 granted, io_in_ready[0]=0 and ptr=1.
6. Assert reset mid-stream with out_valid=1. Next cycle requires io_out_valid=0 and all out bits 0; with all requesters valid, requester 0 wins the first grant.
